// File: rtl/counter_pkg.sv
// Shared constants and helpers for the bounded counter family.
// Mode and direction encodings, plus the load-path clamp.
package counter_pkg;

  localparam int unsigned CALC_W = 64;

  localparam bit MODE_WRAP = 1'b1;
  localparam bit MODE_SAT  = 1'b0;

  localparam bit DIR_UP   = 1'b1;
  localparam bit DIR_DOWN = 1'b0;

  // Saturate a requested load value to the programmed upper bound.
  function automatic logic [CALC_W-1:0] clamp_to_max(input logic [CALC_W-1:0] value,
                                                     input logic [CALC_W-1:0] max);
    logic [CALC_W-1:0] res;
    res = (value > max) ? max : value;
    return res;
  endfunction

endpackage

// File: rtl/bounded_counter_if.sv
// Control/status bundle of a bounded counter.
// master drives the controls; slave is the counter itself.
interface bounded_counter_if #(
  parameter int unsigned N = 8
);

  logic         clr;
  logic         load_en;
  logic [N-1:0] init_count;
  logic         en;
  logic         up;
  logic [N-1:0] count;
  logic         tc;
  logic         cout;
  logic         ovf;

  modport master (
    output clr, load_en, init_count, en, up,
    input  count, tc, cout, ovf
  );

  modport slave (
    input  clr, load_en, init_count, en, up,
    output count, tc, cout, ovf
  );

endinterface

// File: rtl/bounded_counter.sv
// Up/down counter with programmable modulus, wrap or saturate at bounds,
// registered carry/borrow pulse and sticky overflow flag.
module bounded_counter
  import counter_pkg::*;
#(
  parameter int unsigned     N       = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << N) - 64'd1,
  parameter bit              WRAP    = MODE_WRAP
) (
  input logic               clk,
  input logic               rst,
  bounded_counter_if.slave  bus
);

  localparam logic [N-1:0] MAX_C = N'(MAX_VAL);

  // A zero modulus or a bound that does not fit in N bits is a build error.
  if (MAX_VAL == 64'd0 || (N < 64 && MAX_VAL >= (64'd1 << N))) begin : g_bad_max
    $error("bounded_counter: MAX_VAL out of range for counter width");
  end

  logic [N-1:0] count_q, count_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;
  logic         tc_c;
  logic [N-1:0] load_val_c;

  assign tc_c = ((bus.up == DIR_UP)   && (count_q == MAX_C)) ||
                ((bus.up == DIR_DOWN) && (count_q == '0));

  assign load_val_c = N'(clamp_to_max(CALC_W'(bus.init_count), CALC_W'(MAX_C)));

  // Next state: clr > load_en > en; rst is applied in the register.
  always_comb begin
    count_d = count_q;
    cout_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.load_en) begin
      count_d = load_val_c;
    end else if (bus.en) begin
      if (tc_c) begin
        cout_d = 1'b1;
        ovf_d  = 1'b1;
        if (WRAP == MODE_WRAP) begin
          count_d = (bus.up == DIR_UP) ? '0 : MAX_C;
        end
      end else if (bus.up == DIR_UP) begin
        count_d = count_q + N'(1);
      end else begin
        count_d = count_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_c;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_bounded_counter.sv
// Directed scoreboard bench for bounded_counter in three configurations:
// wrap MAX_VAL=9, saturate MAX_VAL=9, wrap MAX_VAL=1 (all N=4).
module tb_bounded_counter;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         clr_v     [3];
  logic         load_en_v [3];
  logic [N-1:0] init_v    [3];
  logic         en_v      [3];
  logic         up_v      [3];
  logic [N-1:0] cnt_w     [3];
  logic         tc_w      [3];
  logic         cout_w    [3];
  logic         ovf_w     [3];

  bounded_counter_if #(.N(N)) if0 ();
  bounded_counter_if #(.N(N)) if1 ();
  bounded_counter_if #(.N(N)) if2 ();

  assign if0.clr = clr_v[0];  assign if0.load_en = load_en_v[0];  assign if0.init_count = init_v[0];
  assign if0.en  = en_v[0];   assign if0.up = up_v[0];
  assign if1.clr = clr_v[1];  assign if1.load_en = load_en_v[1];  assign if1.init_count = init_v[1];
  assign if1.en  = en_v[1];   assign if1.up = up_v[1];
  assign if2.clr = clr_v[2];  assign if2.load_en = load_en_v[2];  assign if2.init_count = init_v[2];
  assign if2.en  = en_v[2];   assign if2.up = up_v[2];

  assign cnt_w[0] = if0.count;  assign tc_w[0] = if0.tc;  assign cout_w[0] = if0.cout;  assign ovf_w[0] = if0.ovf;
  assign cnt_w[1] = if1.count;  assign tc_w[1] = if1.tc;  assign cout_w[1] = if1.cout;  assign ovf_w[1] = if1.ovf;
  assign cnt_w[2] = if2.count;  assign tc_w[2] = if2.tc;  assign cout_w[2] = if2.cout;  assign ovf_w[2] = if2.ovf;

  bounded_counter #(.N(N), .MAX_VAL(9), .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(if0));
  bounded_counter #(.N(N), .MAX_VAL(9), .WRAP(1'b0)) u_sat  (.clk(clk), .rst(rst), .bus(if1));
  bounded_counter #(.N(N), .MAX_VAL(1), .WRAP(1'b1)) u_m1   (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    int           dut;
    string        tag;
    logic [N-1:0] count;
    logic         tc;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic drive(input int d, input logic c, input logic ld, input logic [N-1:0] init,
                       input logic e, input logic u);
    clr_v[d] = c; load_en_v[d] = ld; init_v[d] = init; en_v[d] = e; up_v[d] = u;
  endtask

  task automatic expect_out(input int d, input string tag, input logic [N-1:0] c,
                            input logic t, input logic co, input logic o);
    exp_t x;
    x.dut = d; x.tag = tag; x.count = c; x.tc = t; x.cout = co; x.ovf = o;
    sb.push_back(x);
  endtask

  // Advance one edge, then compare every pending expectation.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      assert (cnt_w[x.dut] === x.count) else begin
        failures++;
        $error("FAIL %s dut%0d count got=%0d exp=%0d", x.tag, x.dut, cnt_w[x.dut], x.count);
      end
      checks++;
      assert (tc_w[x.dut] === x.tc) else begin
        failures++;
        $error("FAIL %s dut%0d tc got=%b exp=%b", x.tag, x.dut, tc_w[x.dut], x.tc);
      end
      checks++;
      assert (cout_w[x.dut] === x.cout) else begin
        failures++;
        $error("FAIL %s dut%0d cout got=%b exp=%b", x.tag, x.dut, cout_w[x.dut], x.cout);
      end
      checks++;
      assert (ovf_w[x.dut] === x.ovf) else begin
        failures++;
        $error("FAIL %s dut%0d ovf got=%b exp=%b", x.tag, x.dut, ovf_w[x.dut], x.ovf);
      end
    end
  endtask

  task automatic step(input int d, input string tag, input logic c, input logic ld,
                      input logic [N-1:0] init, input logic e, input logic u,
                      input logic [N-1:0] ec, input logic et, input logic eco, input logic eo);
    drive(d, c, ld, init, e, u);
    expect_out(d, tag, ec, et, eco, eo);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) expect_out(i, "reset", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // clear mid-count
    step(0, "cnt_a", 0, 0, 0, 1, 1, 4'd1, 0, 0, 0);
    step(0, "cnt_b", 0, 0, 0, 1, 1, 4'd2, 0, 0, 0);
    step(0, "cnt_c", 0, 0, 0, 1, 1, 4'd3, 0, 0, 0);
    step(0, "clr_mid", 1, 0, 0, 1, 1, 4'd0, 0, 0, 0);

    // wrap up 0..9 -> 0
    for (int k = 1; k <= 9; k++)
      step(0, "wrap_up", 0, 0, 0, 1, 1, 4'(k), (k == 9), 0, 0);
    step(0, "wrap_up_evt", 0, 0, 0, 1, 1, 4'd0, 0, 1, 1);
    step(0, "wrap_up_post", 0, 0, 0, 1, 1, 4'd1, 0, 0, 1);
    step(0, "en_off_hold", 0, 0, 0, 0, 1, 4'd1, 0, 0, 1);

    // wrap down from 2
    step(0, "wd_load", 0, 1, 4'd2, 0, 0, 4'd2, 0, 0, 1);
    step(0, "wd_1", 0, 0, 0, 1, 0, 4'd1, 0, 0, 1);
    step(0, "wd_0", 0, 0, 0, 1, 0, 4'd0, 1, 0, 1);
    step(0, "wd_evt", 0, 0, 0, 1, 0, 4'd9, 0, 1, 1);
    step(0, "wd_8", 0, 0, 0, 1, 0, 4'd8, 0, 0, 1);

    // clr clears ovf; clr coincident with a bound event discards it
    step(0, "clr_ovf", 1, 0, 0, 1, 0, 4'd0, 1, 0, 0);
    step(0, "clr_vs_evt", 1, 0, 0, 1, 0, 4'd0, 1, 0, 0);
    step(0, "down_evt", 0, 0, 0, 1, 0, 4'd9, 0, 1, 1);
    // rst coincident with a bound event (count=9, up=1)
    rst = 1'b1;
    step(0, "rst_vs_evt", 0, 0, 0, 1, 1, 4'd0, 0, 0, 0);
    rst = 1'b0;

    // load clamp and priority
    step(0, "ld_clamp", 0, 1, 4'd14, 0, 1, 4'd9, 1, 0, 0);
    step(0, "ld_over_en", 0, 1, 4'd3, 1, 1, 4'd3, 0, 0, 0);
    step(0, "clr_over_ld", 1, 1, 4'd7, 1, 1, 4'd0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);

    // saturate at 9 with back-to-back events
    step(1, "sat_load", 0, 1, 4'd9, 0, 1, 4'd9, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      step(1, "sat_hold", 0, 0, 0, 1, 1, 4'd9, 1, 1, 1);
    step(1, "sat_down", 0, 0, 0, 1, 0, 4'd8, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);

    // MAX_VAL=1 with enable toggling
    step(2, "m1_en1", 0, 0, 0, 1, 1, 4'd1, 1, 0, 0);
    step(2, "m1_en0", 0, 0, 0, 0, 1, 4'd1, 1, 0, 0);
    step(2, "m1_wrap", 0, 0, 0, 1, 1, 4'd0, 0, 1, 1);
    step(2, "m1_en1b", 0, 0, 0, 1, 1, 4'd1, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
